// File: rtl/lv_abist_pkg.sv
// Shared types and sizing helpers for the multi-channel LV analog BIST sequencer.
package lv_abist_pkg;

    typedef enum logic [2:0] {IDLE, SCAN, STIM, REL, DONE} abist_st_e;

    function automatic int unsigned us2cyc(input int unsigned us, input int unsigned clk_m);
        return us * clk_m;
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Width of a counter that must be able to hold max_val without wrapping.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/lv_abist_win_chk.sv
// Window-check engine: debounces a flag towards a target polarity within a cycle window.
module lv_abist_win_chk #(
    parameter int unsigned TMR_W   = 8,
    parameter int unsigned DEB_W   = 3,
    parameter int unsigned DEB_CYC = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             start,
    input  logic             en,
    input  logic             pol,
    input  logic [TMR_W-1:0] win_len,
    input  logic             flag,
    output logic             pass,
    output logic             timeout
);

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = '1;
    localparam logic [DEB_W-1:0] DEB_MAX  = '1;

    logic [TMR_W-1:0] tmr;
    logic [DEB_W-1:0] deb;
    logic             match;

    assign match = (flag == pol);

    // A pass on the last window cycle suppresses the coincident timeout.
    assign pass    = en && match && (deb >= DEB_LAST);
    assign timeout = en && !pass && (tmr >= (win_len - TMR_W'(1)));

    always_ff @(posedge i_clk) begin
        if (i_rst || start) begin
            tmr <= '0;
            deb <= '0;
        end else if (en) begin
            if (tmr != TMR_MAX) begin
                tmr <= tmr + 1'b1;
            end
            if (!match) begin
                deb <= '0;
            end else if (deb != DEB_MAX) begin
                deb <= deb + 1'b1;
            end
        end
    end

endmodule

// File: rtl/lv_abist_mch.sv
// Multi-channel LV analog BIST: forces, checks and releases each monitor in turn,
// then reports per-channel and global results and enables logic BIST.
module lv_abist_mch
    import lv_abist_pkg::*;
#(
    parameter int unsigned CH_NUM  = 4,
    parameter int unsigned CLK_M   = 48,
    parameter int unsigned STIM_US = 70,
    parameter int unsigned REL_US  = 20,
    parameter int unsigned DEB_CYC = 4
) (
    input  logic                                          i_clk,
    input  logic                                          i_rst,
    input  logic                                          i_bist_en,
    input  logic [CH_NUM-1:0]                             i_ch_mask,
    input  logic                                          i_stop_on_fail,
    input  logic [CH_NUM-1:0]                             i_ana_flag,
    output logic [CH_NUM-1:0]                             o_bist_force,
    output logic                                          o_busy,
    output logic                                          o_done,
    output logic                                          o_lbist_en,
    output logic [CH_NUM-1:0]                             o_ch_rult,
    output logic                                          o_abist_rult,
    output logic                                          o_fail_vld,
    output logic [((CH_NUM > 1) ? $clog2(CH_NUM) : 1)-1:0] o_fail_ch
);

    localparam int unsigned STIM_CYC = us2cyc(STIM_US, CLK_M);
    localparam int unsigned REL_CYC  = us2cyc(REL_US, CLK_M);
    localparam int unsigned TMR_W    = cnt_width(max2(STIM_CYC, REL_CYC));
    localparam int unsigned DEB_W    = cnt_width(DEB_CYC);
    localparam int unsigned FAIL_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int unsigned IDX_W    = $clog2(CH_NUM + 1);

    localparam logic [TMR_W-1:0] STIM_LEN = TMR_W'(STIM_CYC);
    localparam logic [TMR_W-1:0] REL_LEN  = TMR_W'(REL_CYC);
    localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(CH_NUM);

    abist_st_e         state;
    logic [IDX_W-1:0]  ch_idx;
    logic [FAIL_W-1:0] ch_sel;
    logic [CH_NUM-1:0] mask_q;
    logic              stop_q;
    logic              ch_failed;

    logic              win_en;
    logic              win_start;
    logic              win_pass;
    logic              win_to;
    logic [TMR_W-1:0]  win_len;

    assign ch_sel       = ch_idx[FAIL_W-1:0];
    assign o_abist_rult = &o_ch_rult;

    // Counters restart on every window entry, i.e. whenever a window is not running or just ended.
    assign win_en    = i_bist_en && ((state == STIM) || (state == REL));
    assign win_start = !win_en || win_pass || win_to;
    assign win_len   = (state == REL) ? REL_LEN : STIM_LEN;

    lv_abist_win_chk #(
        .TMR_W   (TMR_W),
        .DEB_W   (DEB_W),
        .DEB_CYC (DEB_CYC)
    ) u_win_chk (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .start   (win_start),
        .en      (win_en),
        .pol     (state == STIM),
        .win_len (win_len),
        .flag    (i_ana_flag[ch_sel]),
        .pass    (win_pass),
        .timeout (win_to)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            ch_idx       <= '0;
            mask_q       <= '0;
            stop_q       <= 1'b0;
            ch_failed    <= 1'b0;
            o_bist_force <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_lbist_en   <= 1'b0;
            o_ch_rult    <= '1;
            o_fail_vld   <= 1'b0;
            o_fail_ch    <= '0;
        end else if (!i_bist_en && (state != IDLE)) begin
            // Abort: results are kept for inspection until the next start.
            state        <= IDLE;
            o_bist_force <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_lbist_en   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_bist_en) begin
                        state      <= SCAN;
                        mask_q     <= i_ch_mask;
                        stop_q     <= i_stop_on_fail;
                        ch_idx     <= '0;
                        o_ch_rult  <= '1;
                        o_fail_vld <= 1'b0;
                        o_fail_ch  <= '0;
                        o_busy     <= 1'b1;
                        o_done     <= 1'b0;
                        o_lbist_en <= 1'b0;
                    end
                end
                SCAN: begin
                    if (ch_idx == IDX_END) begin
                        state      <= DONE;
                        o_busy     <= 1'b0;
                        o_done     <= 1'b1;
                        o_lbist_en <= 1'b1;
                    end else if (mask_q[ch_sel]) begin
                        ch_idx <= ch_idx + 1'b1;
                    end else begin
                        state        <= STIM;
                        o_bist_force <= CH_NUM'(1) << ch_sel;
                        ch_failed    <= 1'b0;
                    end
                end
                STIM: begin
                    if (win_pass || win_to) begin
                        state        <= REL;
                        o_bist_force <= '0;
                    end
                    if (win_to) begin
                        o_ch_rult[ch_sel] <= 1'b0;
                        ch_failed         <= 1'b1;
                        if (!o_fail_vld) begin
                            o_fail_vld <= 1'b1;
                            o_fail_ch  <= ch_sel;
                        end
                    end
                end
                REL: begin
                    if (win_to) begin
                        o_ch_rult[ch_sel] <= 1'b0;
                        if (!o_fail_vld) begin
                            o_fail_vld <= 1'b1;
                            o_fail_ch  <= ch_sel;
                        end
                    end
                    if (win_pass || win_to) begin
                        if (stop_q && (ch_failed || win_to)) begin
                            state      <= DONE;
                            o_busy     <= 1'b0;
                            o_done     <= 1'b1;
                            o_lbist_en <= 1'b1;
                        end else begin
                            state  <= SCAN;
                            ch_idx <= ch_idx + 1'b1;
                        end
                    end
                end
                DONE: begin
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
